add_mul4: RTL and testbench

ADD_MUL4 -- requirements
Module: add_mul4

---
 rtl/add_mul4.sv | 88 ++++++++
 tb/tb_add_mul4.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/add_mul4.sv
// add_mul4: 4x4 unsigned shift-free multiplier by repeated addition (IDLE/RUN/DONE FSM).
// Optional macro ADD_MUL4_SWAP_EN: iterate over the smaller operand so latency is min(a,b)+2.
module add_mul4 (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] areg;
  logic [3:0] cnt;
  logic [7:0] acc;
  logic [3:0] load_areg;
  logic [3:0] load_cnt;

`ifdef ADD_MUL4_SWAP_EN
  // Larger operand becomes the addend so the loop runs the fewest iterations.
  always_comb begin
    load_areg = a;
    load_cnt  = b;
    if (b > a) begin
      load_areg = b;
      load_cnt  = a;
    end
  end
`else
  assign load_areg = a;
  assign load_cnt  = b;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      areg    <= 4'd0;
      cnt     <= 4'd0;
      acc     <= 8'd0;
      product <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            areg <= load_areg;
            cnt  <= load_cnt;
            acc  <= 8'd0;
          end
        end
        RUN: begin
          // 15*15 fits in 8 bits, so the accumulator never wraps.
          if (cnt != 4'd0) begin
            acc <= acc + {4'd0, areg};
            cnt <= cnt - 4'd1;
          end else begin
            product <= acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN) || (state == DONE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_add_mul4.sv
// Self-checking bench for add_mul4: vector table with a product scoreboard plus corner sequences.
module tb_add_mul4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] a;
  logic [3:0] b;
  logic       start;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic [7:0] vprod;
  } vec_t;

  logic [7:0] sb_q[$];

  add_mul4 dut (
    .clk     (clk),
    .reset   (reset),
    .a       (a),
    .b       (b),
    .start   (start),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_latency(input logic [3:0] ta, input logic [3:0] tb);
`ifdef ADD_MUL4_SWAP_EN
    return ((ta < tb) ? int'(ta) : int'(tb)) + 2;
`else
    return int'(tb) + 2;
`endif
  endfunction

  // Called #1 after an edge while ready=1; returns #1 after the accept edge.
  task automatic start_op(input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tprod);
    a = ta;
    b = tb;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = 4'($urandom);
    b = 4'($urandom);
    sb_q.push_back(tprod);
    check("busy_after_accept", int'(busy), 1);
    check("ready_after_accept", int'(ready), 0);
  endtask

  // Counts edges from the accept edge (edge 1) until done is seen, then scores the product.
  task automatic wait_done(input string name, input int exp_lat);
    int lat;
    logic [7:0] exp_p;
    lat = 1;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_done_seen"}, int'(done), 1);
    check({name, "_latency"}, lat, exp_lat);
    if (sb_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 1, 0);
    end else begin
      exp_p = sb_q.pop_front();
      check({name, "_product"}, int'(product), int'(exp_p));
    end
  endtask

  task automatic no_done_for(input string name, input int cycles);
    int pulses;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) pulses++;
    end
    check({name, "_extra_done"}, pulses, 0);
  endtask

  initial begin
    vec_t vecs[10];
    vecs[0] = '{4'd5,  4'd3,  8'd15};
    vecs[1] = '{4'd15, 4'd15, 8'd225};
    vecs[2] = '{4'd0,  4'd7,  8'd0};
    vecs[3] = '{4'd12, 4'd1,  8'd12};
    vecs[4] = '{4'd3,  4'd3,  8'd9};
    vecs[5] = '{4'd1,  4'd15, 8'd15};
    vecs[6] = '{4'd15, 4'd0,  8'd0};
    vecs[7] = '{4'd9,  4'd9,  8'd81};
    vecs[8] = '{4'd2,  4'd11, 8'd22};
    vecs[9] = '{4'd13, 4'd6,  8'd78};

    reset = 1'b1;
    start = 1'b0;
    a = 4'd0;
    b = 4'd0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_ready", int'(ready), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_product", int'(product), 0);

    // Back-to-back table: each op starts in the first IDLE cycle after the previous done.
    for (int i = 0; i < 10; i++) begin
      start_op(vecs[i].va, vecs[i].vb, vecs[i].vprod);
      wait_done($sformatf("vec%0d", i), exp_latency(vecs[i].va, vecs[i].vb));
      tick();
      check($sformatf("vec%0d_done_one_cycle", i), int'(done), 0);
      check($sformatf("vec%0d_ready_after", i), int'(ready), 1);
      check($sformatf("vec%0d_product_held", i), int'(product), int'(vecs[i].vprod));
    end

    // start held high through RUN and the done cycle must be ignored.
    start_op(4'd4, 4'd6, 8'd24);
    a = 4'd9;
    b = 4'd9;
    start = 1'b1;
    wait_done("ignore_start", exp_latency(4'd4, 4'd6));
    tick();
    start = 1'b0;
    check("ignore_start_ready", int'(ready), 1);
    no_done_for("ignore_start", 20);
    check("ignore_start_product", int'(product), 24);

    // Reset mid-RUN aborts with no done pulse.
    start_op(4'd7, 4'd10, 8'd70);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(sb_q.pop_back());
    check("abort_ready", int'(ready), 1);
    check("abort_busy", int'(busy), 0);
    check("abort_product", int'(product), 0);
    no_done_for("abort", 15);
    start_op(4'd2, 4'd3, 8'd6);
    wait_done("after_abort", exp_latency(4'd2, 4'd3));

    // Reset wins over start in the same cycle.
    tick();
    reset = 1'b1;
    start = 1'b1;
    a = 4'd5;
    b = 4'd5;
    tick();
    reset = 1'b0;
    start = 1'b0;
    check("reset_prio_ready", int'(ready), 1);
    check("reset_prio_busy", int'(busy), 0);
    no_done_for("reset_prio", 10);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
